spi_sram_responder: RTL

- SPI mode-0 target that emulates a 23LC-class serial SRAM. It answers the same command set our spi_ram_controller issues: READ 0x03 and WRITE 0x02, each followed by a 16-bit address.
- Backing store is an internal byte array.
- Used as the far end of the SRAM link in simulation and in on-board loopback builds, so the controller and CPU firmware can run without a physical chip.
- All SPI inputs are oversampled in the system clock domain.

---
 rtl/spi_sram_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 50 +++++
 rtl/spi_sram_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spi_sram_pkg.sv
// Shared constants, mode encodings and FSM states for the SPI SRAM responder.
package spi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDMR  = 8'h05;
  localparam logic [7:0] CMD_WRMR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;

  localparam int PAGE_BITS = 5;

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, RD, WR, MODE_RD, MODE_WR, IGNORE
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes the SPI pins into clk and produces one-clk edge strobes.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic mosi,
  input  logic cs,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic mosi_sync,
  output logic cs_sync
);

  logic [SYNC_STAGES-1:0] sck_q, mosi_q, cs_q;
  logic sck_d, cs_d;

  // cs chain resets deselected so no spurious frame start comes out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q  <= '0;
      mosi_q <= '0;
      cs_q   <= '1;
      sck_d  <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sck_q[0]  <= sck;
      mosi_q[0] <= mosi;
      cs_q[0]   <= cs;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_q[i]  <= sck_q[i-1];
        mosi_q[i] <= mosi_q[i-1];
        cs_q[i]   <= cs_q[i-1];
      end
      sck_d <= sck_q[SYNC_STAGES-1];
      cs_d  <= cs_q[SYNC_STAGES-1];
    end
  end

  assign mosi_sync = mosi_q[SYNC_STAGES-1];
  assign cs_sync   = cs_q[SYNC_STAGES-1];
  assign sck_rise  =  sck_q[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall  = ~sck_q[SYNC_STAGES-1] &  sck_d;
  assign cs_rise   =  cs_q[SYNC_STAGES-1]  & ~cs_d;
  assign cs_fall   = ~cs_q[SYNC_STAGES-1]  &  cs_d;

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 target emulating a 23LC-class SRAM (READ/WRITE, 16-bit address).
// Define SPI_SRAM_RESPONDER_MODE_REG_EN to add the RDMR/WRMR mode register.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic mosi,
  input  logic cs,
  output logic miso,
  output logic miso_oe,
  output logic active
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_sync, cs_sync;
  state_t state, state_n;
  logic [2:0]  bit_cnt;
  logic [15:0] addr, addr_adv, addr_lo_full;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_byte, tx_shift;
  logic [1:0]  mode;
  logic        is_rd, last, wr_en;
  logic [7:0]  mem [DEPTH];

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .cs(cs),
    .sck_rise(sck_rise), .sck_fall(sck_fall), .cs_rise(cs_rise),
    .cs_fall(cs_fall), .mosi_sync(mosi_sync), .cs_sync(cs_sync)
  );

  function automatic logic [15:0] adv(input logic [15:0] a, input logic [1:0] m);
    logic [15:0] n;
    n = a;
    case (m)
      MODE_BYTE: ;
      MODE_PAGE: n[PAGE_BITS-1:0] = a[PAGE_BITS-1:0] + 1'b1;
      default:   n[ADDR_BITS-1:0] = a[ADDR_BITS-1:0] + 1'b1;
    endcase
    return n;
  endfunction

  assign rx_byte      = {rx_shift, mosi_sync};
  assign last         = (bit_cnt == 3'd7);
  assign addr_lo_full = {addr[15:8], rx_byte};
  assign addr_adv     = adv(addr, mode);
  assign active       = ~cs_sync;
  assign wr_en        = !reset && !cs_rise && state == WR && sck_rise && last;

`ifdef SPI_SRAM_RESPONDER_MODE_REG_EN
  always_ff @(posedge clk) begin
    if (reset)
      mode <= MODE_SEQ;
    else if (!cs_rise && state == MODE_WR && sck_rise && last)
      mode <= rx_byte[7:6];
  end
`else
  assign mode = MODE_SEQ;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    miso_oe = (state == RD) || (state == MODE_RD);
    if (cs_rise) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall) state_n = CMD;
        CMD: if (sck_rise && last) begin
          case (rx_byte)
            CMD_READ, CMD_WRITE: state_n = ADDR_HI;
`ifdef SPI_SRAM_RESPONDER_MODE_REG_EN
            CMD_RDMR: state_n = MODE_RD;
            CMD_WRMR: state_n = MODE_WR;
`endif
            default: state_n = IGNORE;
          endcase
        end
        ADDR_HI: if (sck_rise && last) state_n = ADDR_LO;
        ADDR_LO: if (sck_rise && last) state_n = is_rd ? RD : WR;
        MODE_WR: if (sck_rise && last) state_n = IGNORE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[ADDR_BITS'(addr)] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      addr     <= '0;
      miso     <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      is_rd    <= 1'b0;
    end else if (cs_rise) begin
      bit_cnt <= '0;
    end else if (state != IDLE) begin
      if (sck_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte[6:0];
        if (last) begin
          case (state)
            CMD: begin
              is_rd    <= (rx_byte == CMD_READ);
              tx_shift <= {mode, 6'b0};
            end
            ADDR_HI: addr[15:8] <= rx_byte;
            ADDR_LO: begin
              addr     <= addr_lo_full;
              tx_shift <= mem[ADDR_BITS'(addr_lo_full)];
            end
            WR: addr <= addr_adv;
            default: ;
          endcase
        end
      end
      // The 8th fall of a byte emits its last bit and preloads the next byte.
      if (sck_fall && (state == RD || state == MODE_RD)) begin
        miso <= tx_shift[7];
        if (!last)
          tx_shift <= {tx_shift[6:0], 1'b0};
        else if (state == RD) begin
          addr     <= addr_adv;
          tx_shift <= mem[ADDR_BITS'(addr_adv)];
        end else
          tx_shift <= {mode, 6'b0};
      end
    end
  end

endmodule
